matvec_arbiter: RTL and testbench

- Shares one matrix-vector engine (streaming 14-bit W/X inputs, 28-bit saturated outputs, new_matrix reuse) between NREQ requesters.
- Grants a whole job at a time: input beats in, then S results out. Round-robin fairness between jobs.
- Tracks which requester owns the W currently loaded, so a new_matrix=0 job only runs against its own matrix.
- Sits between the requester streams and the engine's input/output valid-ready ports.

---
 rtl/matvec_arbiter.sv | 167 ++++++++++++++++
 tb/tb_matvec_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_arbiter.sv
// rtl/matvec_arbiter.sv - whole-job round-robin arbiter sharing one matrix-vector engine
// W ownership is tracked so a reuse (new_matrix=0) job only runs against its owner's matrix.
module matvec_arbiter #(
  parameter int DATA_W = 14,
  parameter int OUT_W  = 28,
  parameter int S      = 3,
  parameter int NREQ   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_new_matrix,
  output logic [NREQ-1:0]          res_valid,
  input  logic [NREQ-1:0]          res_ready,
  output logic [OUT_W-1:0]         res_data,
  output logic                     eng_input_valid,
  input  logic                     eng_input_ready,
  output logic [DATA_W-1:0]        eng_input_data,
  output logic                     eng_new_matrix,
  input  logic                     eng_output_valid,
  output logic                     eng_output_ready,
  input  logic [OUT_W-1:0]         eng_output_data,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);
  localparam int GW     = $clog2(NREQ);
  localparam int IN_TGT = S * S + S;
  localparam int CW     = $clog2(IN_TGT + 1);
  localparam int OCW    = $clog2(S + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   w_owner_q;
  logic            w_valid_q;
  logic            job_new_q;
  logic [CW-1:0]   in_cnt_q;
  logic [OCW-1:0]  out_cnt_q;

  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   rr_ptr_d;
  logic [CW-1:0]   in_cnt_d;
  logic [CW-1:0]   in_tgt;
  logic [OCW-1:0]  out_cnt_d;
  logic            in_fire;
  logic            out_fire;
  logic            in_last;
  logic            out_last;

  // A reuse job is only eligible when this requester owns the loaded W.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (req_new_matrix[i] || (w_valid_q && (w_owner_q == GW'(i))));
    end
  end

  // Scan from the far end so the index closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (elig[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    req_ready        = '0;
    res_valid        = '0;
    eng_input_valid  = 1'b0;
    eng_output_ready = 1'b0;
    eng_new_matrix   = 1'b0;
    eng_input_data   = req_data[int'(grant_q) * DATA_W +: DATA_W];
    case (state_q)
      FEED: begin
        eng_input_valid    = req_valid[grant_q];
        req_ready[grant_q] = eng_input_ready;
        eng_new_matrix     = job_new_q;
      end
      DRAIN: begin
        res_valid[grant_q] = eng_output_valid;
        eng_output_ready   = res_ready[grant_q];
        eng_new_matrix     = job_new_q;
      end
      default: ;
    endcase
  end

  assign res_data  = eng_output_data;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;

  assign in_fire   = eng_input_valid && eng_input_ready;
  assign out_fire  = eng_output_valid && eng_output_ready;
  assign in_cnt_d  = in_cnt_q + 1'b1;
  assign out_cnt_d = out_cnt_q + 1'b1;
  assign in_tgt    = job_new_q ? CW'(IN_TGT) : CW'(S);
  assign in_last   = (in_cnt_d == in_tgt);
  assign out_last  = (out_cnt_d == OCW'(S));
  assign rr_ptr_d  = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      w_valid_q <= 1'b0;
      w_owner_q <= '0;
      job_new_q <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_q   <= win_idx;
            job_new_q <= req_new_matrix[win_idx];
            in_cnt_q  <= '0;
            state_q   <= FEED;
          end
        end
        FEED: begin
          if (in_fire) begin
            in_cnt_q <= in_cnt_d;
            if (in_last) begin
              state_q   <= DRAIN;
              out_cnt_q <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            out_cnt_q <= out_cnt_d;
            if (out_last) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_ptr_d;
              // W ownership only changes once the new matrix job has fully completed.
              if (job_new_q) begin
                w_valid_q <= 1'b1;
                w_owner_q <= grant_q;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_arbiter.sv
// tb/tb_matvec_arbiter.sv - self-checking bench for matvec_arbiter with a behavioural engine
module tb_matvec_arbiter;
  localparam int DATA_W = 14;
  localparam int OUT_W  = 28;
  localparam int S      = 3;
  localparam int NREQ   = 2;
  localparam longint SMAX = 134217727;
  localparam longint SMIN = -134217728;

  typedef longint mat_t [9];
  typedef longint vec_t [3];
  typedef logic [DATA_W-1:0] beat_q_t [$];
  typedef longint res_q_t [$];

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_new_matrix;
  logic [NREQ-1:0]        res_valid;
  logic [NREQ-1:0]        res_ready;
  logic [OUT_W-1:0]       res_data;
  logic                   eng_input_valid;
  logic                   eng_input_ready;
  logic [DATA_W-1:0]      eng_input_data;
  logic                   eng_new_matrix;
  logic                   eng_output_valid;
  logic                   eng_output_ready;
  logic [OUT_W-1:0]       eng_output_data;
  logic                   busy;
  logic [0:0]             grant_id;

  int total = 0;
  int bad   = 0;
  mat_t model_w;
  int   owner = -1;

  matvec_arbiter #(.DATA_W(DATA_W), .OUT_W(OUT_W), .S(S), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_new_matrix(req_new_matrix),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .eng_input_valid(eng_input_valid), .eng_input_ready(eng_input_ready),
    .eng_input_data(eng_input_data), .eng_new_matrix(eng_new_matrix),
    .eng_output_valid(eng_output_valid), .eng_output_ready(eng_output_ready),
    .eng_output_data(eng_output_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic longint sat_ref(longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // Behavioural engine: collects W (row-major) then X, streams S saturated dot products.
  logic   eng_phase;
  int     e_cnt, e_oidx;
  bit     e_nm, e_nmj, eng_rdy_rand, stall_en;
  longint ew [9];
  longint ex [3];
  longint e_sum, e_sat;

  always @(negedge clk) eng_rdy_rand <= stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  assign eng_input_ready  = !eng_phase && eng_rdy_rand;
  assign eng_output_valid = eng_phase;
  always @* e_nmj = (e_cnt == 0) ? eng_new_matrix : e_nm;
  always @* begin
    e_sum = 0;
    for (int c = 0; c < 3; c++) e_sum = e_sum + ew[e_oidx * 3 + c] * ex[c];
    e_sat = sat_ref(e_sum);
    eng_output_data = e_sat[OUT_W-1:0];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_phase <= 1'b0; e_cnt <= 0; e_oidx <= 0; e_nm <= 1'b0;
    end else if (!eng_phase) begin
      if (eng_input_valid && eng_input_ready) begin
        e_nm <= e_nmj;
        if (e_nmj && e_cnt < 9) ew[e_cnt] <= longint'($signed(eng_input_data));
        else ex[e_nmj ? e_cnt - 9 : e_cnt] <= longint'($signed(eng_input_data));
        if (e_cnt + 1 == (e_nmj ? 12 : 3)) begin
          eng_phase <= 1'b1; e_cnt <= 0; e_oidx <= 0;
        end else e_cnt <= e_cnt + 1;
      end
    end else if (eng_output_ready) begin
      if (e_oidx == 2) begin eng_phase <= 1'b0; e_oidx <= 0; end
      else e_oidx <= e_oidx + 1;
    end
  end

  // Grant recorder: requester of each job start and idle cycles preceding it.
  int gseq [$];
  int gaps_q [$];
  int idle_run = 0;
  bit busy_prev = 0;
  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      gseq.push_back(int'(grant_id));
      gaps_q.push_back(idle_run);
    end
    idle_run  = busy ? 0 : idle_run + 1;
    busy_prev = busy;
  end

  function automatic longint rand14();
    logic signed [DATA_W-1:0] t;
    t = DATA_W'($urandom);
    return longint'(t);
  endfunction

  task automatic rand_job(output mat_t w, output vec_t x);
    for (int i = 0; i < 9; i++) w[i] = rand14();
    for (int i = 0; i < 3; i++) x[i] = rand14();
  endtask

  task automatic ref_job(input mat_t w, input vec_t x, output res_q_t y);
    longint s;
    y.delete();
    for (int r = 0; r < 3; r++) begin
      s = 0;
      for (int c = 0; c < 3; c++) s = s + w[r * 3 + c] * x[c];
      y.push_back(sat_ref(s));
    end
  endtask

  task automatic make_beats(input bit nm, input mat_t w, input vec_t x, output beat_q_t b);
    longint v;
    b.delete();
    if (nm) for (int i = 0; i < 9; i++) begin v = w[i]; b.push_back(v[DATA_W-1:0]); end
    for (int i = 0; i < 3; i++) begin v = x[i]; b.push_back(v[DATA_W-1:0]); end
  endtask

  task automatic drive_job(input int r, input bit nm, input beat_q_t beats, input bit gaps,
                           output int acc, output bit nm_bad);
    int i = 0;
    int cyc = 0;
    acc = 0; nm_bad = 0;
    while (i < beats.size() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (gaps && $urandom_range(0, 3) == 0) req_valid[r] = 1'b0;
      else begin
        req_valid[r] = 1'b1;
        req_new_matrix[r] = nm;
        req_data[r * DATA_W +: DATA_W] = beats[i];
      end
      #1;
      if (req_valid[r] && req_ready[r]) begin
        if (eng_new_matrix !== nm) nm_bad = 1;
        i++; acc++;
      end
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
    req_new_matrix[r] = 1'b0;
  endtask

  task automatic collect(input int r, input int n, input bit rnd, output res_q_t got, output bit leak);
    int cyc = 0;
    got.delete(); leak = 0;
    while (got.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      res_ready[r] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if ($countones(res_valid) > 1) leak = 1;
      if (res_valid[r] && res_ready[r]) got.push_back(longint'($signed(res_data)));
    end
    @(negedge clk);
    res_ready[r] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++;
    if ({req_ready, res_valid, eng_input_valid, eng_output_ready, eng_new_matrix, busy} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {req_ready, res_valid, eng_input_valid, eng_output_ready, eng_new_matrix, busy});
    end
    total++;
    if (grant_id !== 1'b0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || eng_input_valid !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: busy=%b eng_input_valid=%b want 0", busy, eng_input_valid);
    end
  endtask

  task automatic test_first_job();
    mat_t wi = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    vec_t x  = '{5, -7, 9};
    longint e [3] = '{5, -7, 9};
    beat_q_t b; res_q_t got; int acc; bit nmb, leak;
    make_beats(1, wi, x, b);
    fork
      drive_job(0, 1, b, 0, acc, nmb);
      collect(0, 3, 0, got, leak);
    join
    total++; if (acc !== 12) begin bad++; $display("FAIL first_beats: got %0d want 12", acc); end
    total++; if (nmb) begin bad++; $display("FAIL first_new_matrix: got 0 want 1"); end
    total++; if (leak) begin bad++; $display("FAIL first_res_route: got multiple res_valid want one"); end
    total++; if (got.size() != 3) begin bad++; $display("FAIL first_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== e[i]) begin bad++; $display("FAIL first_result%0d: got %0d want %0d", i, got[i], e[i]); end
    end
    model_w = wi; owner = 0;
  endtask

  task automatic test_reuse();
    vec_t x = '{2, 3, 4};
    longint e [3] = '{2, 3, 4};
    beat_q_t b; res_q_t got; int acc; bit nmb, leak;
    make_beats(0, model_w, x, b);
    fork
      drive_job(0, 0, b, 0, acc, nmb);
      collect(0, 3, 0, got, leak);
    join
    total++; if (acc !== 3) begin bad++; $display("FAIL reuse_beats: got %0d want 3", acc); end
    total++; if (nmb) begin bad++; $display("FAIL reuse_new_matrix: got 1 want 0"); end
    total++; if (got.size() != 3) begin bad++; $display("FAIL reuse_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== e[i]) begin bad++; $display("FAIL reuse_result%0d: got %0d want %0d", i, got[i], e[i]); end
    end
  endtask

  task automatic test_ineligible();
    mat_t w2 = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    vec_t x  = '{1, 1, 1};
    beat_q_t b; res_q_t got; int acc; bit nmb, leak, seen;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid[1] = 1'b1; req_new_matrix[1] = 1'b0; req_data[DATA_W +: DATA_W] = 14'd7;
      #1;
      if (busy || req_ready[1]) seen = 1;
    end
    req_valid[1] = 1'b0;
    total++; if (seen) begin bad++; $display("FAIL b_reuse_ineligible: got granted want never"); end
    make_beats(1, w2, x, b);
    fork
      drive_job(1, 1, b, 0, acc, nmb);
      collect(1, 3, 0, got, leak);
    join
    total++; if (acc !== 12) begin bad++; $display("FAIL b_new_beats: got %0d want 12", acc); end
    total++; if (got.size() != 3) begin bad++; $display("FAIL b_new_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== 6) begin bad++; $display("FAIL b_new_result%0d: got %0d want 6", i, got[i]); end
    end
    model_w = w2; owner = 1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      req_valid[0] = 1'b1; req_new_matrix[0] = 1'b0;
      #1;
      if (busy || req_ready[0]) seen = 1;
    end
    req_valid[0] = 1'b0;
    total++; if (seen) begin bad++; $display("FAIL a_lost_ownership: got granted want never"); end
  endtask

  task automatic test_simultaneous();
    mat_t wa1, wa2, wb1, wb2; vec_t xa1, xa2, xb1, xb2;
    beat_q_t ba1, ba2, bb1, bb2; res_q_t ya, yb, t, gota, gotb;
    int acc0, acc1, acc2, acc3; bit n0, n1, n2, n3, la, lb;
    int eseq [4] = '{0, 1, 0, 1};
    rand_job(wa1, xa1); rand_job(wa2, xa2); rand_job(wb1, xb1); rand_job(wb2, xb2);
    ref_job(wa1, xa1, ya); ref_job(wa2, xa2, t); foreach (t[i]) ya.push_back(t[i]);
    ref_job(wb1, xb1, yb); ref_job(wb2, xb2, t); foreach (t[i]) yb.push_back(t[i]);
    make_beats(1, wa1, xa1, ba1); make_beats(1, wa2, xa2, ba2);
    make_beats(1, wb1, xb1, bb1); make_beats(1, wb2, xb2, bb2);
    gseq.delete(); gaps_q.delete();
    fork
      begin drive_job(0, 1, ba1, 0, acc0, n0); drive_job(0, 1, ba2, 0, acc1, n1); end
      begin drive_job(1, 1, bb1, 0, acc2, n2); drive_job(1, 1, bb2, 0, acc3, n3); end
      collect(0, 6, 0, gota, la);
      collect(1, 6, 0, gotb, lb);
    join
    total++;
    if (acc0 + acc1 + acc2 + acc3 !== 48) begin bad++; $display("FAIL sim_beats: got %0d want 48", acc0 + acc1 + acc2 + acc3); end
    total++; if (la || lb) begin bad++; $display("FAIL sim_res_route: got multiple res_valid want one"); end
    total++; if (gseq.size() != 4) begin bad++; $display("FAIL sim_grant_count: got %0d want 4", gseq.size()); end
    for (int i = 0; i < 4 && i < gseq.size(); i++) begin
      total++;
      if (gseq[i] !== eseq[i]) begin bad++; $display("FAIL sim_grant_order%0d: got %0d want %0d", i, gseq[i], eseq[i]); end
    end
    for (int i = 1; i < 4 && i < gaps_q.size(); i++) begin
      total++;
      if (gaps_q[i] !== 1) begin bad++; $display("FAIL sim_job_gap%0d: got %0d want 1", i, gaps_q[i]); end
    end
    total++;
    if (gota.size() != 6 || gotb.size() != 6) begin bad++; $display("FAIL sim_result_count: got %0d/%0d want 6/6", gota.size(), gotb.size()); end
    for (int i = 0; i < 6 && i < gota.size(); i++) begin
      total++;
      if (gota[i] !== ya[i]) begin bad++; $display("FAIL sim_a_result%0d: got %0d want %0d", i, gota[i], ya[i]); end
    end
    for (int i = 0; i < 6 && i < gotb.size(); i++) begin
      total++;
      if (gotb[i] !== yb[i]) begin bad++; $display("FAIL sim_b_result%0d: got %0d want %0d", i, gotb[i], yb[i]); end
    end
    model_w = wb2; owner = 1;
  endtask

  task automatic test_backpressure();
    mat_t w = '{-8192, -8192, -8192, 1, 2, 3, 8191, 8191, 8191};
    vec_t x = '{-8192, -8192, -8192};
    longint e [3] = '{134217727, -49152, -134217728};
    beat_q_t b; res_q_t got; int acc; bit nmb, leak, seen, hold_bad;
    logic [OUT_W-1:0] d0;
    make_beats(1, w, x, b);
    seen = 0; hold_bad = 0; d0 = '0;
    fork
      drive_job(1, 1, b, 0, acc, nmb);
      begin
        for (int c = 0; c < 500 && !seen; c++) begin
          @(negedge clk); #1;
          if (res_valid[1]) begin seen = 1; d0 = res_data; end
        end
        for (int c = 0; c < 10 && seen; c++) begin
          @(negedge clk);
          res_ready[0] = 1'($urandom_range(0, 1));
          #1;
          if (eng_output_ready !== 1'b0 || res_valid[1] !== 1'b1 || res_valid[0] !== 1'b0 || res_data !== d0) hold_bad = 1;
        end
        res_ready[0] = 1'b0;
        collect(1, 3, 0, got, leak);
      end
    join
    total++; if (!seen) begin bad++; $display("FAIL bp_result_wait: got timeout want res_valid"); end
    total++; if (hold_bad) begin bad++; $display("FAIL bp_hold: got output moved want held"); end
    total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== e[i]) begin bad++; $display("FAIL bp_result%0d: got %0d want %0d", i, got[i], e[i]); end
    end
    model_w = w; owner = 1;
  endtask

  task automatic test_reset_midjob();
    mat_t w; vec_t x; beat_q_t b; int cnt, cyc; bit busy_before, seen;
    rand_job(w, x);
    make_beats(1, w, x, b);
    stall_en = 0; cnt = 0; cyc = 0;
    while (cnt < 5 && cyc < 200) begin
      @(negedge clk); cyc++;
      req_valid[0] = 1'b1; req_new_matrix[0] = 1'b1; req_data[0 +: DATA_W] = b[cnt];
      #1;
      if (req_ready[0]) cnt++;
    end
    @(negedge clk); #1;
    busy_before = busy;
    #1;
    reset = 1'b0;
    #1;
    total++; if (busy_before !== 1'b1) begin bad++; $display("FAIL rst_busy_before: got %b want 1", busy_before); end
    total++;
    if ({req_ready, res_valid, eng_input_valid, eng_output_ready, eng_new_matrix, busy} !== '0) begin
      bad++; $display("FAIL rst_async_outputs: got %b want 0", {req_ready, res_valid, eng_input_valid, eng_output_ready, eng_new_matrix, busy});
    end
    req_valid[0] = 1'b0; req_new_matrix[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    owner = -1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      req_valid[0] = 1'b1; req_new_matrix[0] = 1'b0;
      #1;
      if (busy || req_ready[0] || res_valid !== '0) seen = 1;
    end
    req_valid[0] = 1'b0;
    total++; if (seen) begin bad++; $display("FAIL rst_w_invalid: got granted want never"); end
  endtask

  task automatic test_random();
    mat_t w; vec_t x; beat_q_t b; res_q_t y, got; int acc, r; bit nm, nmb, leak;
    stall_en = 1;
    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(0, 1);
      nm = (owner != r) ? 1'b1 : 1'($urandom_range(0, 1));
      rand_job(w, x);
      if (!nm) w = model_w;
      ref_job(w, x, y);
      make_beats(nm, w, x, b);
      fork
        drive_job(r, nm, b, 1, acc, nmb);
        collect(r, 3, 1, got, leak);
      join
      total++;
      if (acc !== (nm ? 12 : 3) || nmb) begin bad++; $display("FAIL rnd%0d_beats: got %0d want %0d", it, acc, nm ? 12 : 3); end
      total++; if (int'(grant_id) !== r) begin bad++; $display("FAIL rnd%0d_grant: got %0d want %0d", it, grant_id, r); end
      total++; if (got.size() != 3) begin bad++; $display("FAIL rnd%0d_count: got %0d want 3", it, got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
        total++;
        if (got[i] !== y[i]) begin bad++; $display("FAIL rnd%0d_result%0d: got %0d want %0d", it, i, got[i], y[i]); end
      end
      if (nm) begin model_w = w; owner = r; end
    end
    stall_en = 0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0; req_data = '0; req_new_matrix = '0; res_ready = '0;
    stall_en = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_first_job();
    test_reuse();
    test_ineligible();
    test_simultaneous();
    test_backpressure();
    test_reset_midjob();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
